vga_pattern_src: RTL and testbench
==================================

Name: vga_pattern_src

Overview:
- Frame pattern source for the SDRAM write path. On a frame-start pulse from the memory arbiter it emits exactly H_ACTIVE*V_ACTIVE RGB565 pixels in raster order.
- Each pixel is emitted only when the arbiter signals write readiness. The arbiter writes them into the frame buffer that the VGA controller later reads.
- Four selectable patterns cover visual check and memory-integrity check.

Parameters:
- H_ACTIVE, 1024, pixels per line; power of two, max 1024.
- V_ACTIVE, 768, lines per frame; max 1024.
- BAR_W, 128, colour-bar width in pixels; power of two.

Ports:
- clk  input  1  write-side clock (50 MHz domain).
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle pulse: generate a new frame.
- pattern_i  input  2  pattern select; sampled only when start_i is accepted.
- wr_en  input  1  arbiter ready to accept a pixel this cycle (level).
- data_en  output  1  dout valid; exactly one pixel per high cycle.
- dout  output  16  RGB565 pixel, {R[4:0],G[5:0],B[4:0]}.
- busy_o  output  1  frame in progress.
- frame_done_o  output  1  one-cycle pulse after the last pixel is emitted.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: data_en=0, dout=16'h0000, busy_o=0, frame_done_o=0, state=IDLE, x=0, y=0, pix_idx=0, pattern register=0.
- Internal counters:
  - x: 0..H_ACTIVE-1.
  - y: 0..V_ACTIVE-1.
  - pix_idx: 20-bit running pixel index, 0..H_ACTIVE*V_ACTIVE-1.
- FSM IDLE:
  - start_i=1 → latch pattern_i, clear x, y and pix_idx, go to RUN.
  - busy_o goes 1 on the following cycle.
- FSM RUN:
  - On each clk edge with wr_en=1: data_en<=1, dout<=f(pattern,x,y,pix_idx), then advance the counters.
  - Latency: one cycle from wr_en sampled high to data_en high.
  - Advance rule: x increments; at x=H_ACTIVE-1, x wraps to 0 and y increments. pix_idx increments every advance.
  - Edge with wr_en=0: data_en<=0; counters and dout hold.
  - Last pixel: when the pixel at x=H_ACTIVE-1, y=V_ACTIVE-1 is emitted, go to DONE.
- FSM DONE:
  - data_en<=0, frame_done_o<=1 for exactly one cycle, busy_o<=0, go to IDLE.
- start_i is ignored in RUN and DONE: no restart and no pattern change. A start_i in the same cycle as DONE is also ignored.
- Pixel functions (width-exact, no saturation):
  - 0, colour bars: i=(x/BAR_W) mod 8 selects FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 for i=0..7.
  - 1, checker: (x[5]^y[5]) ? FFFF : 0000.
  - 2, gradient: {x[9:5], y[9:4], x[9:5]^y[9:5]}.
  - 3, address ramp: pix_idx[15:0]; used for SDRAM readback verification.
- Output count: data_en is high exactly H_ACTIVE*V_ACTIVE times per accepted start_i, regardless of wr_en gaps.
- Reset mid-frame: all outputs return to reset values immediately. No frame_done_o pulse. The next start_i restarts from pixel 0.
- Arithmetic: counters sized $clog2 of their maxima; x/BAR_W implemented as a shift.

Test Plan:
- Reset hold, then release, no start_i → data_en=0, dout=0000, busy_o=0 for 100 cycles.
- start_i with pattern_i=3, wr_en tied 1 → busy_o=1; 786432 data_en cycles, contiguous.
  - dout sequence 0000,0001,...,FFFF repeating; final dout=FFFF.
  - frame_done_o pulses once, one cycle after the last data_en.
- pattern_i=0, wr_en=1 → first 128 pixels FFFF, pixels 128..255 FFE0, pixel 1023 = 0000, pixel 1024 (y=1, x=0) = FFFF.
- pattern_i=3, wr_en random 30% duty → total data_en count 786432; dout strictly sequential across gaps; no data_en in cycles following wr_en=0.
- Second start_i pulsed mid-frame with pattern_i=1 → ignored: pattern stays 3 and the count is unchanged. After frame_done_o, start_i with pattern_i=1 → pixel(32,0)=FFFF, pixel(32,32)=0000.
- rst_n asserted after 5000 pixels → data_en, busy_o=0 asynchronously, no frame_done_o. A new start_i (pattern 3) then yields first dout=0000.

Source files
------------

// File: rtl/vga_pattern_src.sv
// -----------------------------------------------------------------------------
// vga_pattern_src
//
// Frame pattern source for the SDRAM write path. A start_i pulse while idle
// launches one frame of exactly H_ACTIVE*V_ACTIVE RGB565 pixels in raster
// order. Pixels are produced only on cycles where the arbiter asserts wr_en.
// The arbiter stores them into the frame buffer that the VGA controller
// scans out later.
//
// Handshake: wr_en is the arbiter's "ready" level. Each clock edge in RUN that
// samples wr_en=1 produces one pixel. That pixel appears on dout, with
// data_en=1, for the single following cycle. data_en is the "valid" flag and
// marks exactly one pixel per high cycle. There is no back-pressure on
// data_en, because the arbiter has already committed to taking the pixel.
// An edge that samples wr_en=0 drops data_en and holds dout and the counters.
//
// Ports
//   clk          in   write-side clock (50 MHz domain)
//   rst_n        in   asynchronous active-low reset
//   start_i      in   one-cycle pulse: generate a new frame (accepted in IDLE)
//   pattern_i    in   [1:0] pattern select, latched only when start_i is accepted
//   wr_en        in   arbiter ready to accept a pixel this cycle
//   data_en      out  dout valid, one pixel per high cycle
//   dout         out  [15:0] RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   busy_o       out  frame in progress
//   frame_done_o out  one-cycle pulse the cycle after the last pixel
//
// Patterns
//   0 colour bars, 1 checker (32x32), 2 gradient, 3 address ramp (pix_idx[15:0])
// -----------------------------------------------------------------------------
module vga_pattern_src #(
  parameter int H_ACTIVE = 1024,  // pixels per line, power of two, <= 1024
  parameter int V_ACTIVE = 768,   // lines per frame, <= 1024
  parameter int BAR_W    = 128    // colour-bar width, power of two
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  pattern_i,
  input  logic        wr_en,
  output logic        data_en,
  output logic [15:0] dout,
  output logic        busy_o,
  output logic        frame_done_o
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PW     = 20;
  localparam int BAR_SH = $clog2(BAR_W);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [XW-1:0]   x;
  logic [XW-1:0]   x_nxt;
  logic [YW-1:0]   y;
  logic [YW-1:0]   y_nxt;
  logic [PW-1:0]   pix_idx;
  logic [PW-1:0]   pix_idx_nxt;
  logic [1:0]      pattern_q;
  logic [1:0]      pattern_nxt;

  logic            data_en_nxt;
  logic [15:0]     dout_nxt;
  logic            busy_nxt;
  logic            frame_done_nxt;

  // ---------------------------------------------------------------------------
  // Pixel function
  // ---------------------------------------------------------------------------
  // The pattern formulas address bits up to [9] of x and y. Widening both
  // counters to 10 bits lets smaller frame geometries read absent upper bits
  // as zero instead of indexing out of range.
  logic [9:0]      x10;
  logic [9:0]      y10;
  logic [2:0]      bar_idx;
  logic [15:0]     bar_colour;
  logic [15:0]     pix_val;

  assign x10     = 10'(x);
  assign y10     = 10'(y);
  // x/BAR_W mod 8: a shift, then keep the low three bits.
  assign bar_idx = 3'(x10 >> BAR_SH);

  always_comb begin
    bar_colour = 16'h0000;
    case (bar_idx)
      3'd0: bar_colour = 16'hFFFF;  // white
      3'd1: bar_colour = 16'hFFE0;  // yellow
      3'd2: bar_colour = 16'h07FF;  // cyan
      3'd3: bar_colour = 16'h07E0;  // green
      3'd4: bar_colour = 16'hF81F;  // magenta
      3'd5: bar_colour = 16'hF800;  // red
      3'd6: bar_colour = 16'h001F;  // blue
      3'd7: bar_colour = 16'h0000;  // black
      default: bar_colour = 16'h0000;
    endcase
  end

  always_comb begin
    pix_val = 16'h0000;
    case (pattern_q)
      2'd0: pix_val = bar_colour;
      2'd1: pix_val = (x10[5] ^ y10[5]) ? 16'hFFFF : 16'h0000;
      2'd2: pix_val = {x10[9:5], y10[9:4], x10[9:5] ^ y10[9:5]};
      2'd3: pix_val = pix_idx[15:0];
      default: pix_val = 16'h0000;
    endcase
  end

  // pix_idx is a full 20-bit frame index. Only the ramp pattern reads it, and
  // it reads just the low 16 bits. y10[3:0] is likewise unused by every
  // pattern.
  logic unused_bits;
  assign unused_bits = ^{pix_idx[PW-1:16], y10[3:0]};

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    x_nxt          = x;
    y_nxt          = y;
    pix_idx_nxt    = pix_idx;
    pattern_nxt    = pattern_q;
    data_en_nxt    = 1'b0;
    dout_nxt       = dout;
    busy_nxt       = busy_o;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          pattern_nxt = pattern_i;
          x_nxt       = '0;
          y_nxt       = '0;
          pix_idx_nxt = '0;
          busy_nxt    = 1'b1;
          state_nxt   = RUN;
        end
      end

      RUN: begin
        // start_i is deliberately not looked at here: a frame in flight is
        // never restarted or re-patterned.
        if (wr_en) begin
          data_en_nxt = 1'b1;
          dout_nxt    = pix_val;
          pix_idx_nxt = pix_idx + 1'b1;
          if (x == X_LAST) begin
            x_nxt = '0;
            if (y == Y_LAST) begin
              y_nxt     = '0;
              state_nxt = DONE;
            end else begin
              y_nxt = y + 1'b1;
            end
          end else begin
            x_nxt = x + 1'b1;
          end
        end
      end

      DONE: begin
        frame_done_nxt = 1'b1;
        busy_nxt       = 1'b0;
        state_nxt      = IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x            <= '0;
      y            <= '0;
      pix_idx      <= '0;
      pattern_q    <= 2'd0;
      data_en      <= 1'b0;
      dout         <= 16'h0000;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      x            <= x_nxt;
      y            <= y_nxt;
      pix_idx      <= pix_idx_nxt;
      pattern_q    <= pattern_nxt;
      data_en      <= data_en_nxt;
      dout         <= dout_nxt;
      busy_o       <= busy_nxt;
      frame_done_o <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_vga_pattern_src.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_src
//
// Bench for vga_pattern_src, using a reduced 64x64 frame with 8-pixel bars.
// Inputs are driven, and outputs sampled, on the falling clock edge. Expected
// pixels come from ref_pix(), which computes each pixel from its frame index
// using plain arithmetic. They are queued in exp_q and popped on every data_en.
// -----------------------------------------------------------------------------
module tb_vga_pattern_src;

  localparam int H     = 64;
  localparam int V     = 64;
  localparam int BW    = 8;
  localparam int TOTAL = H * V;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  pattern_i = 2'd0;
  logic        wr_en = 1'b0;
  logic        data_en;
  logic [15:0] dout;
  logic        busy_o;
  logic        frame_done_o;

  always #10 clk = ~clk;

  vga_pattern_src #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .BAR_W    (BW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .pattern_i    (pattern_i),
    .wr_en        (wr_en),
    .data_en      (data_en),
    .dout         (dout),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cap_q[$];

  function automatic logic [15:0] ref_pix(input int pat, input int n);
    logic [15:0] bars [8];
    int px;
    int py;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    px = n % H;
    py = n / H;
    case (pat)
      0: return bars[(px / BW) % 8];
      1: return (((px / 32) % 2) != ((py / 32) % 2)) ? 16'hFFFF : 16'h0000;
      2: return 16'((((px / 32) % 32) << 11) | (((py / 16) % 64) << 5) |
                    (((px / 32) ^ (py / 32)) % 32));
      default: return 16'(n % 65536);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one full frame with wr_en at the given duty percentage. When
  // mid_pat >= 0, a start_i carrying that pattern is pulsed part-way through;
  // it must be ignored.
  // ---------------------------------------------------------------------------
  task automatic run_frame(input int pat, input int duty, input int mid_pat,
                           input string name);
    int          n;
    int          cycles;
    int          limit;
    logic        prev_wr;
    logic [15:0] e;
    exp_q.delete();
    cap_q.delete();
    for (int i = 0; i < TOTAL; i++) exp_q.push_back(ref_pix(pat, i));

    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_busy: got %b want 0", name, busy_o);
    end
    start_i   = 1'b1;
    pattern_i = 2'(pat);
    wr_en     = 1'b0;
    @(negedge clk);
    start_i   = 1'b0;
    pattern_i = 2'(pat + 1);  // later changes must not leak into the frame
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy_o);
    end

    n      = 0;
    cycles = 0;
    limit  = (TOTAL * 100 / duty) * 3 + 1000;
    while (n < TOTAL && cycles < limit) begin
      wr_en   = ($urandom_range(0, 99) < duty);
      prev_wr = wr_en;
      if (mid_pat >= 0 && cycles == 50) begin
        start_i   = 1'b1;
        pattern_i = 2'(mid_pat);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cycles++;
      tests++;
      if (data_en !== prev_wr) begin
        fails++;
        $display("FAIL %s data_en pix=%0d: got %b want %b", name, n, data_en, prev_wr);
      end
      tests++;
      if (frame_done_o !== 1'b0 || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL %s running_flags pix=%0d: got done=%b busy=%b want 0/1",
                 name, n, frame_done_o, busy_o);
      end
      if (data_en === 1'b1) begin
        e = exp_q.pop_front();
        cap_q.push_back(dout);
        tests++;
        if (dout !== e) begin
          fails++;
          $display("FAIL %s dout pix=%0d: got %h want %h", name, n, dout, e);
        end
        n++;
      end else if (n > 0) begin
        e = ref_pix(pat, n - 1);
        tests++;
        if (dout !== e) begin
          fails++;
          $display("FAIL %s dout_hold pix=%0d: got %h want %h", name, n, dout, e);
        end
      end
    end
    start_i = 1'b0;
    tests++;
    if (n != TOTAL) begin
      fails++;
      $display("FAIL %s pixel_count: got %0d want %0d (timeout)", name, n, TOTAL);
    end

    // Keep wr_en high: no pixel may appear once the frame is complete.
    wr_en = 1'b1;
    @(negedge clk);
    tests++;
    if (frame_done_o !== 1'b1 || busy_o !== 1'b0 || data_en !== 1'b0) begin
      fails++;
      $display("FAIL %s done_cycle: got done=%b busy=%b de=%b want 1/0/0",
               name, frame_done_o, busy_o, data_en);
    end
    tests++;
    if (dout !== ref_pix(pat, TOTAL - 1)) begin
      fails++;
      $display("FAIL %s final_dout: got %h want %h", name, dout, ref_pix(pat, TOTAL - 1));
    end
    @(negedge clk);
    tests++;
    if (frame_done_o !== 1'b0 || busy_o !== 1'b0 || data_en !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: got done=%b busy=%b de=%b want 0/0/0",
               name, frame_done_o, busy_o, data_en);
    end
    wr_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (data_en !== 1'b0 || dout !== 16'h0000 || busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got de=%b dout=%h busy=%b done=%b want 0/0000/0/0",
               data_en, dout, busy_o, frame_done_o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'(i % 2);
      @(negedge clk);
      tests++;
      if (data_en !== 1'b0 || dout !== 16'h0000 || busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d: got de=%b dout=%h busy=%b done=%b want 0/0000/0/0",
                 i, data_en, dout, busy_o, frame_done_o);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_ramp_full();
    run_frame(3, 100, -1, "ramp_full");
    tests++;
    if (cap_q.size() != TOTAL || cap_q[TOTAL-1] !== 16'(TOTAL - 1)) begin
      fails++;
      $display("FAIL ramp_last: got size=%0d want %0d", cap_q.size(), TOTAL);
    end
  endtask

  task automatic test_bars();
    run_frame(0, 100, -1, "bars");
    tests++;
    if (cap_q.size() != TOTAL) begin
      fails++;
      $display("FAIL bars_size: got %0d want %0d", cap_q.size(), TOTAL);
    end else begin
      tests++;
      if (cap_q[0] !== 16'hFFFF || cap_q[BW-1] !== 16'hFFFF || cap_q[BW] !== 16'hFFE0 ||
          cap_q[2*BW-1] !== 16'hFFE0 || cap_q[H-1] !== 16'h0000 || cap_q[H] !== 16'hFFFF) begin
        fails++;
        $display("FAIL bars_points: got %h %h %h %h %h %h want FFFF FFFF FFE0 FFE0 0000 FFFF",
                 cap_q[0], cap_q[BW-1], cap_q[BW], cap_q[2*BW-1], cap_q[H-1], cap_q[H]);
      end
    end
  endtask

  task automatic test_ramp_gaps();
    // A start_i carrying the checker pattern is pulsed mid-frame; it must be ignored.
    run_frame(3, 30, 1, "ramp_gaps");
  endtask

  task automatic test_checker();
    run_frame(1, 100, -1, "checker");
    tests++;
    if (cap_q.size() != TOTAL || cap_q[32] !== 16'hFFFF || cap_q[32*H+32] !== 16'h0000) begin
      fails++;
      $display("FAIL checker_points: size=%0d", cap_q.size());
    end
  endtask

  task automatic test_gradient();
    run_frame(2, 60, 0, "gradient");
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int cycles;
    start_i   = 1'b1;
    pattern_i = 2'd3;
    @(negedge clk);
    start_i = 1'b0;
    wr_en   = 1'b1;
    n       = 0;
    cycles  = 0;
    while (n < TOTAL / 2 && cycles < TOTAL) begin
      @(negedge clk);
      cycles++;
      if (data_en === 1'b1) n++;
    end
    tests++;
    if (n != TOTAL / 2) begin
      fails++;
      $display("FAIL rstmid_progress: got %0d want %0d", n, TOTAL / 2);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (data_en !== 1'b0 || busy_o !== 1'b0 || dout !== 16'h0000 || frame_done_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: got de=%b busy=%b dout=%h done=%b want 0/0/0000/0",
               data_en, busy_o, dout, frame_done_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (frame_done_o !== 1'b0 || data_en !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_hold cyc=%0d: got done=%b de=%b want 0/0", i, frame_done_o, data_en);
      end
    end
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(3, 70, -1, "ramp_after_reset");
    tests++;
    if (cap_q.size() == 0 || cap_q[0] !== 16'h0000) begin
      fails++;
      $display("FAIL rstmid_first_pixel: size=%0d want first pixel 0000", cap_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_ramp_full();
    test_bars();
    test_ramp_gaps();
    test_checker();
    test_gradient();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
